// File: rtl/pattern_player.sv
// LED pattern player: fetches one pattern word per step from a shared, arbitrated
// read port and shows it on the LEDs; pushbuttons select which sequence plays.
module pattern_player #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 10,
    parameter int SEQ_LEN = 64,
    parameter int NUM_SEQ = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                       CLK_50,
    input  logic                       reset_n,
    input  logic                       step_tick,
    input  logic                       seq_up,
    input  logic                       seq_dn,
    input  logic                       run,
    output logic                       mem_req,
    input  logic                       mem_gnt,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic [DATA_W-1:0]          led,
    output logic [$clog2(NUM_SEQ)-1:0] seq_num,
    output logic [$clog2(SEQ_LEN)-1:0] step_num,
    output logic                       busy,
    output logic                       overrun,
    output logic [1:0]                 state_dbg
);

    localparam int SEQ_W = $clog2(NUM_SEQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        wait_cnt;
    logic              pend_valid;
    logic              pend_up;
    logic              chg_now;
    logic              apply_chg;
    logic              apply_up;
    logic [SEQ_W-1:0]  seq_inc;
    logic [SEQ_W-1:0]  seq_dec;
    logic [ADDR_W-1:0] fetch_addr;

    // Handshake: mem_req stays high with a stable mem_addr until mem_gnt is seen
    // high on a rising edge; that edge is the address cycle and mem_req drops after it.
    // Read data is expected MEM_LAT edges after the address cycle.

    // Opposite buttons in the same cycle cancel; a live press overrides a pending one.
    assign chg_now    = seq_up ^ seq_dn;
    assign apply_chg  = (state == S_IDLE) && (chg_now || pend_valid);
    assign apply_up   = chg_now ? seq_up : pend_up;
    assign seq_inc    = (seq_num == SEQ_W'(NUM_SEQ - 1)) ? '0 : seq_num + SEQ_W'(1);
    assign seq_dec    = (seq_num == '0) ? SEQ_W'(NUM_SEQ - 1) : seq_num - SEQ_W'(1);
    assign fetch_addr = ADDR_W'(32'(seq_num) * 32'(SEQ_LEN) + 32'(step_num));

    assign mem_req   = (state == S_REQ);
    assign mem_addr  = mem_req ? fetch_addr : '0;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (apply_chg || (run && step_tick)) state_nxt = S_REQ;
            S_REQ:  if (mem_gnt) state_nxt = (MEM_LAT == 1) ? S_SHOW : S_WAIT;
            S_WAIT: if (wait_cnt == '0) state_nxt = S_SHOW;
            S_SHOW: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt   <= '0;
            led        <= '0;
            seq_num    <= '0;
            step_num   <= '0;
            overrun    <= 1'b0;
            pend_valid <= 1'b0;
            pend_up    <= 1'b0;
        end else begin
            // WAIT spans MEM_LAT-1 cycles, so the counter starts one below that.
            if (state == S_REQ && mem_gnt) begin
                wait_cnt <= 2'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 2'd1;
            end

            // SEQ_LEN is a power of two, so the step counter wraps on its own.
            if (state == S_SHOW) begin
                led      <= mem_rdata;
                step_num <= step_num + 1'b1;
            end

            if (apply_chg) begin
                seq_num    <= apply_up ? seq_inc : seq_dec;
                step_num   <= '0;
                pend_valid <= 1'b0;
            end else if (busy && chg_now) begin
                pend_valid <= 1'b1;
                pend_up    <= seq_up;
            end

            if (busy && run && step_tick) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player: an arbiter with programmable grant delay and a
// pattern memory with a two-cycle read pipeline sit around the DUT.
module tb_pattern_player;

    logic       CLK_50;
    logic       reset_n;
    logic       step_tick;
    logic       seq_up;
    logic       seq_dn;
    logic       run;
    logic       mem_req;
    logic       mem_gnt;
    logic [9:0] mem_addr;
    logic [9:0] mem_rdata;
    logic [9:0] led;
    logic [3:0] seq_num;
    logic [5:0] step_num;
    logic       busy;
    logic       overrun;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int gnt_delay = 0;
    int req_age = 0;
    int n_gnt = 0;
    int g0;

    logic [9:0] pipe0 = '0;
    logic [9:0] pipe1 = '0;
    logic       v0 = 1'b0;
    logic       v1 = 1'b0;
    logic       grant_seen = 1'b0;
    logic       prev_req = 1'b0;
    logic [9:0] prev_addr = '0;
    logic       mon_en = 1'b0;

    pattern_player dut (
        .CLK_50    (CLK_50),
        .reset_n   (reset_n),
        .step_tick (step_tick),
        .seq_up    (seq_up),
        .seq_dn    (seq_dn),
        .run       (run),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .led       (led),
        .seq_num   (seq_num),
        .step_num  (step_num),
        .busy      (busy),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial CLK_50 = 1'b0;
    always #10 CLK_50 = ~CLK_50;

    function automatic logic [9:0] pat(input int a);
        int t;
        t = a * 37 + 5;
        return t[9:0];
    endfunction

    // arbiter: grant after req has been pending gnt_delay edges
    assign mem_gnt = (req_age >= gnt_delay);
    always @(posedge CLK_50) begin
        req_age    <= (mem_req && !mem_gnt) ? req_age + 1 : 0;
        grant_seen <= mem_req && mem_gnt;
        if (mem_req && mem_gnt) begin
            n_gnt <= n_gnt + 1;
            pipe0 <= mem_addr;
        end
        v0    <= mem_req && mem_gnt;
        v1    <= v0;
        pipe1 <= pipe0;
    end
    // data is only correct in the one cycle it is due; otherwise inverted garbage
    assign mem_rdata = v1 ? pat(int'(pipe1)) : ~pat(int'(pipe1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // protocol monitor: single-beat request, address stable while stalled
    always @(negedge CLK_50) begin
        if (mon_en) begin
            if (grant_seen) check("req_after_gnt", 32'(mem_req), 32'd0);
            else if (prev_req && mem_req) check("addr_stable", 32'(mem_addr), 32'(prev_addr));
        end
        prev_req  <= mem_req;
        prev_addr <= mem_addr;
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(posedge CLK_50);
        #1;
    endtask

    task automatic tick();
        step_tick = 1'b1;
        cyc(1);
        step_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            cyc(1);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; step_tick = 1'b0; seq_up = 1'b0; seq_dn = 1'b0; run = 1'b0;
        do_reset();
        mon_en = 1'b1;

        // reset state
        check("rst_led", 32'(led), 32'd0);
        check("rst_seq", 32'(seq_num), 32'd0);
        check("rst_step", 32'(step_num), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);

        // single fetch with grant held high
        run = 1'b1; gnt_delay = 0; g0 = n_gnt;
        tick();
        check("g_req", 32'(mem_req), 32'd1);
        check("g_addr", 32'(mem_addr), 32'd0);
        check("g_state_req", 32'(state_dbg), 32'd1);
        cyc(1);
        check("g_req_drop", 32'(mem_req), 32'd0);
        check("g_state_wait", 32'(state_dbg), 32'd2);
        cyc(1);
        check("g_state_show", 32'(state_dbg), 32'd3);
        check("g_led_early", 32'(led), 32'd0);
        cyc(1);
        check("g_led", 32'(led), 32'(pat(0)));
        check("g_step", 32'(step_num), 32'd1);
        check("g_idle", 32'(busy), 32'd0);
        check("g_fetches", 32'(n_gnt - g0), 32'd1);

        // full wrap of a sequence with a stalled arbiter
        do_reset();
        run = 1'b1; gnt_delay = 5;
        for (int i = 0; i < 64; i++) begin
            tick();
            wait_idle(40);
            check("w_led", 32'(led), 32'(pat(i)));
            check("w_step", 32'(step_num), 32'((i + 1) % 64));
            cyc(2);
        end
        check("w_seq", 32'(seq_num), 32'd0);
        check("w_ovr", 32'(overrun), 32'd0);

        // run = 0 ignores ticks, also while busy
        do_reset();
        run = 1'b0; gnt_delay = 0; g0 = n_gnt;
        tick();
        check("r0_busy", 32'(busy), 32'd0);
        cyc(5);
        check("r0_fetch", 32'(n_gnt - g0), 32'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        wait_idle(20);
        check("r0_ovr", 32'(overrun), 32'd0);
        check("r0_step", 32'(step_num), 32'd1);

        // overrun: second tick one cycle after the first
        do_reset();
        run = 1'b1; gnt_delay = 0; g0 = n_gnt;
        tick();
        tick();
        wait_idle(20);
        cyc(4);
        check("o_ovr", 32'(overrun), 32'd1);
        check("o_fetch", 32'(n_gnt - g0), 32'd1);
        check("o_step", 32'(step_num), 32'd1);
        tick();
        wait_idle(20);
        check("o_sticky", 32'(overrun), 32'd1);
        check("o_step2", 32'(step_num), 32'd2);

        // sequence change coinciding with a tick in IDLE
        do_reset();
        run = 1'b1; gnt_delay = 0; g0 = n_gnt;
        seq_up = 1'b1; step_tick = 1'b1;
        cyc(1);
        seq_up = 1'b0; step_tick = 1'b0;
        check("c_seq", 32'(seq_num), 32'd1);
        check("c_addr", 32'(mem_addr), 32'd64);
        wait_idle(20);
        cyc(3);
        check("c_ovr", 32'(overrun), 32'd0);
        check("c_fetch", 32'(n_gnt - g0), 32'd1);
        check("c_led", 32'(led), 32'(pat(64)));

        // sequence wrap downwards, cancel, wrap upwards
        do_reset();
        run = 1'b0;
        seq_dn = 1'b1;
        cyc(1);
        seq_dn = 1'b0;
        check("s_seq15", 32'(seq_num), 32'd15);
        check("s_addr960", 32'(mem_addr), 32'd960);
        check("s_req", 32'(mem_req), 32'd1);
        wait_idle(20);
        check("s_led960", 32'(led), 32'(pat(960)));
        check("s_step", 32'(step_num), 32'd1);
        seq_up = 1'b1; seq_dn = 1'b1;
        cyc(1);
        seq_up = 1'b0; seq_dn = 1'b0;
        cyc(3);
        check("s_cancel_busy", 32'(busy), 32'd0);
        check("s_cancel_seq", 32'(seq_num), 32'd15);
        check("s_cancel_step", 32'(step_num), 32'd1);
        seq_up = 1'b1;
        cyc(1);
        seq_up = 1'b0;
        check("s_seq0", 32'(seq_num), 32'd0);
        check("s_addr0", 32'(mem_addr), 32'd0);
        wait_idle(20);

        // pending change latched during WAIT
        do_reset();
        run = 1'b1; gnt_delay = 0;
        tick();
        cyc(1);
        check("p_wait", 32'(state_dbg), 32'd2);
        seq_up = 1'b1;
        cyc(1);
        seq_up = 1'b0;
        check("p_seq_held", 32'(seq_num), 32'd0);
        cyc(1);
        check("p_idle", 32'(state_dbg), 32'd0);
        check("p_led0", 32'(led), 32'(pat(0)));
        check("p_step1", 32'(step_num), 32'd1);
        cyc(1);
        check("p_seq1", 32'(seq_num), 32'd1);
        check("p_step0", 32'(step_num), 32'd0);
        check("p_addr64", 32'(mem_addr), 32'd64);
        wait_idle(20);
        check("p_led64", 32'(led), 32'(pat(64)));
        // two changes while busy: the newer one wins
        tick();
        check("n_addr65", 32'(mem_addr), 32'd65);
        seq_up = 1'b1;
        cyc(1);
        seq_up = 1'b0; seq_dn = 1'b1;
        cyc(1);
        seq_dn = 1'b0;
        wait_idle(20);
        check("n_led65", 32'(led), 32'(pat(65)));
        cyc(1);
        check("n_seq", 32'(seq_num), 32'd0);
        check("n_addr", 32'(mem_addr), 32'd0);
        wait_idle(20);
        check("n_led0", 32'(led), 32'(pat(0)));

        // reset while requesting
        do_reset();
        run = 1'b1; gnt_delay = 3;
        tick();
        check("x_req", 32'(mem_req), 32'd1);
        #5 reset_n = 1'b0;
        #1;
        check("x_req_async", 32'(mem_req), 32'd0);
        check("x_addr_async", 32'(mem_addr), 32'd0);
        check("x_busy_async", 32'(busy), 32'd0);
        cyc(1);
        reset_n = 1'b1;
        cyc(4);
        check("x_stay_idle", 32'(busy), 32'd0);
        // reset after the grant: late data must not reach the LEDs
        gnt_delay = 0;
        tick();
        cyc(1);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(4);
        check("x_led", 32'(led), 32'd0);
        check("x_step", 32'(step_num), 32'd0);
        check("x_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_player.md
PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning pattern memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 10, meaning pattern word width (one bit per LED).
REQ-003 The block SHALL have parameter SEQ_LEN, default 64, meaning entries per sequence; power of two.
REQ-004 The block SHALL have parameter NUM_SEQ, default 16, meaning number of sequences; NUM_SEQ*SEQ_LEN <= 2^ADDR_W.
REQ-005 The block SHALL have parameter MEM_LAT, default 2, meaning cycles from granted address to valid read data (1..3).
REQ-006 The block SHALL have port CLK_50  in  1  the single system clock; all logic rising-edge.
REQ-007 The block SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-008 The block SHALL have port step_tick  in  1  one-cycle pulse from the throttle; requests the next step.
REQ-009 The block SHALL have port seq_up  in  1  one-cycle pulse (debounced pushbutton); select next sequence.
REQ-010 The block SHALL have port seq_dn  in  1  one-cycle pulse (debounced pushbutton); select previous sequence.
REQ-011 The block SHALL have port run  in  1  level; 1 = play, 0 = pause.
REQ-012 The block SHALL have port mem_req  out  1  request for the shared memory read port.
REQ-013 The block SHALL have port mem_gnt  in  1  grant from the memory arbiter.
REQ-014 The block SHALL have port mem_addr  out  ADDR_W  read address, valid while mem_req = 1.
REQ-015 The block SHALL have port mem_rdata  in  DATA_W  read data from the shared port.
REQ-016 The block SHALL have port led  out  DATA_W  registered displayed pattern.
REQ-017 The block SHALL have ports seq_num  out  clog2(NUM_SEQ) and step_num  out  clog2(SEQ_LEN), the current sequence and step.
REQ-018 The block SHALL have ports busy  out  1  (FSM not IDLE) and overrun  out  1  (sticky dropped-tick flag).

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT and SHOW.
REQ-020 In IDLE with run = 1 and step_tick = 1, the FSM SHALL go to REQ on the next edge.
REQ-021 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal seq_num*SEQ_LEN + step_num, truncated to ADDR_W.
REQ-022 REQ SHALL hold, with mem_addr stable, until mem_gnt is sampled 1; that edge is the address cycle.
REQ-023 mem_req SHALL be 0 in the cycle after the grant edge (single-beat request, no back-to-back).
REQ-024 WAIT SHALL last MEM_LAT-1 cycles.
REQ-025 In SHOW, led SHALL load mem_rdata exactly MEM_LAT cycles after the grant edge, and step_num SHALL advance.
REQ-026 From SHOW the FSM SHALL return to IDLE on the next edge.
REQ-027 step_num SHALL wrap from SEQ_LEN-1 to 0; seq_num SHALL NOT change on wrap.
REQ-028 A step_tick arriving while busy = 1 and run = 1 SHALL be dropped and SHALL set overrun; overrun clears only on reset.
REQ-029 step_tick with run = 0 SHALL be ignored and SHALL NOT set overrun.
REQ-030 seq_up SHALL increment seq_num, wrapping NUM_SEQ-1 -> 0; seq_dn SHALL decrement it, wrapping 0 -> NUM_SEQ-1.
REQ-031 seq_up and seq_dn asserted in the same cycle SHALL cancel; no change.
REQ-032 A sequence change arriving while busy SHALL be latched as one pending change (newest wins) and applied on entry to IDLE.
REQ-033 Applying a sequence change SHALL set step_num to 0 and start an immediate fetch of step 0 (IDLE -> REQ) regardless of run.
REQ-034 A sequence change coinciding with step_tick in IDLE SHALL take priority; the tick is consumed without overrun.
REQ-035 led SHALL change only in SHOW.

Reset
REQ-036 reset_n = 0 SHALL asynchronously force IDLE, mem_req = 0, mem_addr = 0, led = 0, seq_num = 0, step_num = 0, busy = 0, overrun = 0, and clear the pending change.
REQ-037 Reset mid-transaction SHALL abandon it; read data arriving after reset release SHALL NOT load led.
REQ-038 After reset release, the block SHALL remain in IDLE until the first qualifying step_tick or sequence change.

Verification
REQ-039 Grant: run = 1, mem_gnt held 1, one tick -> mem_req high 1 cycle, addr 0, led = mem[0] at grant+2, step_num = 1.
REQ-040 Wrap and stall: 64 ticks spaced 10 cycles apart with mem_gnt withheld 5 cycles -> step_num returns to 0, led = mem[63], addr stable throughout.
REQ-041 Overrun: tick, then a second tick 1 cycle later -> overrun = 1, only one fetch, step_num = 1.
REQ-042 Sequence wrap: seq_dn at seq 0 -> seq_num = 15, fetch addr 960; then seq_up and seq_dn together -> no change.
REQ-043 Pending change: seq_up during WAIT -> current step completes, then fetch addr 64 with step_num = 0.
REQ-044 Reset in REQ: reset_n low during REQ -> mem_req = 0 immediately; no led update after release.
